led_share_arbiter: RTL
======================

Name: led_share_arbiter

Overview:
Shares the board's three status LEDs (LED0..LED2) between two independent pattern sources, e.g. a heartbeat chase and an alert blinker. It contains its own slow-tick prescaler, a round-robin ownership FSM with a minimum hold time counted in ticks, and registered LED outputs. It sits between the pattern generators and the LED pins and drives the per-requester grants.

Parameters:
CLK_DIV, 50_000_000, clk cycles per slow tick; legal range ≥1.
HOLD_TICKS, 4, minimum ownership in ticks before a contended handover; legal range ≥1.
DIV_W, 32, prescaler counter width; must hold CLK_DIV-1.
HOLD_W, 8, hold counter width; must hold HOLD_TICKS.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 wants the LEDs
pat0  in  3  requester 0 pattern {LED2,LED1,LED0}
req1  in  1  requester 1 wants the LEDs
pat1  in  3  requester 1 pattern {LED2,LED1,LED0}
gnt0  out  1  requester 0 owns the LEDs
gnt1  out  1  requester 1 owns the LEDs
tick  out  1  one-cycle slow-tick strobe
LED0  out  1  LED bit 0
LED1  out  1  LED bit 1
LED2  out  1  LED bit 2

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed): state=IDLE, gnt0=gnt1=0, LED0..2=0, tick=0, prescaler=0, hold=0, last=1 (req0 wins first contention).
- Prescaler counts 0..CLK_DIV-1 and wraps to 0. tick is registered high for exactly one cycle as the count wraps, giving period CLK_DIV. With CLK_DIV=1, tick is high every cycle after reset.
- FSM states: IDLE, OWN0, OWN1. gnt0=(state==OWN0) and gnt1=(state==OWN1), decoded from the state register. Grants are one-hot, never both high.
- IDLE transitions, evaluated every clock (not tick-gated):
  - req0 only → OWN0.
  - req1 only → OWN1.
  - Both → OWNx, where x != last.
  - Entering OWNx loads hold=HOLD_TICKS and sets last=x.
- OWNx, evaluated every clock, first matching rule wins:
  1. reqx=0 → release. Other req high → OWN(other) with hold reload and last update. Otherwise → IDLE.
  2. tick with hold>1 → hold-=1.
  3. tick with hold==1 (expiry). Other req high → OWN(other) with reload. Otherwise stay in OWNx and reload hold=HOLD_TICKS.
- Ownership therefore lasts HOLD_TICKS ticks under contention; the first tick period may be partial.
- LEDs are registered every clock:
  - OWN0 → {LED2,LED1,LED0}=pat0.
  - OWN1 → pat1.
  - IDLE → 000.
  - Latency: LEDs reflect the grant one cycle after gnt rises. Pattern changes by the owner appear one cycle later.
- Handover is back-to-back: there is no IDLE cycle between OWN0 and OWN1, and the gnt swap happens on a single edge.
- A req change coincident with tick resolves by rule order: release beats expiry.
- Reset asserted mid-ownership clears all outputs immediately. After release, arbitration restarts with last=1.

Test Plan:
(CLK_DIV=4, HOLD_TICKS=2 unless noted.)
- Reset/tick: hold rst_n low 3 cycles, then release with no reqs. Required: all outputs 0 while in reset; tick pulses every 4th cycle, 1 cycle wide; LEDs stay 000.
- Single requester: raise req0 with pat0=101. Required: gnt0=1 after the next edge; LEDs=101 one cycle later. Change pat0 to 010 → LEDs=010 one cycle later. Grant is held across multiple expiries. Drop req0 → gnt0=0 next edge, LEDs=000 one cycle after.
- Simultaneous first contention: after reset, raise req0 and req1 on the same cycle with pat0=001, pat1=100. Required: gnt0 first. After 2 ticks, gnt1=1 and gnt0=0 on the same edge; LEDs=100 one cycle later. Ownership then alternates every 2 ticks.
- Early release: while OWN1 with req0 pending, drop req1 mid-hold. Required: gnt0=1 on the next edge, without waiting for a tick.
- Release vs expiry: drop the owner's req on the exact cycle tick=1 at hold==1, with the other req low. Required: state goes to IDLE, gnts 0, LEDs 000.
- Async reset mid-ownership: assert rst_n low between clock edges while gnt1=1. Required: gnt1, LEDs and tick go 0 immediately. After release with both reqs high, gnt0 is granted first.

Source files
------------

// File: rtl/led_share_arbiter.sv
// Two-requester round-robin owner of the three status LEDs, with a built-in
// slow-tick prescaler and a minimum ownership time counted in ticks.
module led_share_arbiter #(
  parameter int unsigned CLK_DIV    = 50_000_000,
  parameter int unsigned HOLD_TICKS = 4,
  parameter int unsigned DIV_W      = 32,
  parameter int unsigned HOLD_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [2:0] pat0,
  input  logic       req1,
  input  logic [2:0] pat1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       tick,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2
);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  logic [DIV_W-1:0]  r_div;
  logic              r_tick;
  state_t            r_state;
  state_t            w_state_next;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_next;
  logic              r_last;
  logic              w_last_next;
  logic              w_take_en;
  logic              w_take_sel;
  logic [2:0]        r_led;

  // Prescaler: the strobe is registered on the wrap so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + DIV_ONE;
      r_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
      r_last  <= w_last_next;
    end
  end

  // Release is tested before expiry so a req drop on a tick cycle wins.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_last_next  = r_last;
    w_take_en    = 1'b0;
    w_take_sel   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req0 && req1) begin
          w_take_en  = 1'b1;
          w_take_sel = ~r_last;
        end else if (req0) begin
          w_take_en  = 1'b1;
          w_take_sel = 1'b0;
        end else if (req1) begin
          w_take_en  = 1'b1;
          w_take_sel = 1'b1;
        end
      end
      ST_OWN0: begin
        if (!req0) begin
          if (req1) begin
            w_take_en  = 1'b1;
            w_take_sel = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (r_tick) begin
          if (r_hold > HOLD_ONE) begin
            w_hold_next = r_hold - HOLD_ONE;
          end else if (req1) begin
            w_take_en  = 1'b1;
            w_take_sel = 1'b1;
          end else begin
            w_hold_next = HOLD_LOAD;
          end
        end
      end
      ST_OWN1: begin
        if (!req1) begin
          if (req0) begin
            w_take_en  = 1'b1;
            w_take_sel = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else if (r_tick) begin
          if (r_hold > HOLD_ONE) begin
            w_hold_next = r_hold - HOLD_ONE;
          end else if (req0) begin
            w_take_en  = 1'b1;
            w_take_sel = 1'b0;
          end else begin
            w_hold_next = HOLD_LOAD;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (w_take_en) begin
      w_state_next = w_take_sel ? ST_OWN1 : ST_OWN0;
      w_hold_next  = HOLD_LOAD;
      w_last_next  = w_take_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= 3'b000;
    end else begin
      case (r_state)
        ST_OWN0: r_led <= pat0;
        ST_OWN1: r_led <= pat1;
        default: r_led <= 3'b000;
      endcase
    end
  end

  assign gnt0 = (r_state == ST_OWN0);
  assign gnt1 = (r_state == ST_OWN1);
  assign tick = r_tick;
  assign LED0 = r_led[0];
  assign LED1 = r_led[1];
  assign LED2 = r_led[2];

endmodule
